uart_txr_fifo: RTL and testbench

Parametrised successor to the team's fixed 8N1 UART transmitter. Accepts words through a valid/ready write port into an internal FIFO and serialises them onto a single UART data line. Data width, parity mode, stop-bit count, baud divisor and buffer depth are all configurable. Frames go out back-to-back with no idle gap while the FIFO holds data. Sits between any byte producer in the design and the board TX pin.

---
 rtl/uart_txr_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_txr_fifo.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txr_fifo.sv
// UART transmitter with a valid/ready write FIFO. Frames go out back-to-back
// while words are queued; data width, parity, stop bits and baud are parameters.
module uart_txr_fifo #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_BITS-1:0]        i_data,
    input  logic                        i_data_valid,
    output logic                        o_ready,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
    output logic                        o_dataline,
    output logic                        o_busy,
    output logic                        o_send_complete
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        if (PARITY == 1) return ~(^w);
        return ^w;
    endfunction

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 done_q, done_d;
    logic                 bit_end, fifo_has;

    assign o_ready  = (count_q < FULL_CNT);
    assign push     = i_data_valid & o_ready;
    assign head     = mem_q[rd_ptr_q];
    assign fifo_has = (count_q != '0);
    assign bit_end  = (bit_cnt_q == BIT_LAST);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    // A pop happens from IDLE or on the last stop-bit cycle, so the next
    // start bit follows the previous stop bit with no idle gap.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q != S_IDLE)
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (fifo_has) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        done_d = 1'b1;
                        if (fifo_has) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d = head;
            par_d   = parity_bit(head);
        end

        // The line is registered from the next state so the pin never glitches.
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
            S_PARITY: line_d = par_d;
            default:  line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            line_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign o_dataline      = line_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_send_complete = done_q;
    assign o_fifo_count    = count_q;

endmodule

// File: tb/tb_uart_txr_fifo.sv
// Bench for uart_txr_fifo: three parameterisations, a frame-table pass, directed
// corner sequences and a random run against a cycle-level reference model.
module tb_uart_txr_fifo;
    localparam int C     = 10;
    localparam int FLEN0 = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dat = '0;
    logic       vld     [3];
    logic       rdy_o   [3];
    logic [2:0] cnt_o   [3];
    logic       line_o  [3];
    logic       busy_o  [3];
    logic       done_o  [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_txr_fifo u_d0 (
        .i_clk(clk), .i_rst(rst), .i_data(dat), .i_data_valid(vld[0]),
        .o_ready(rdy_o[0]), .o_fifo_count(cnt_o[0]), .o_dataline(line_o[0]),
        .o_busy(busy_o[0]), .o_send_complete(done_o[0])
    );

    uart_txr_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_data(dat[6:0]), .i_data_valid(vld[1]),
        .o_ready(rdy_o[1]), .o_fifo_count(cnt_o[1]), .o_dataline(line_o[1]),
        .o_busy(busy_o[1]), .o_send_complete(done_o[1])
    );

    uart_txr_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_data(dat[6:0]), .i_data_valid(vld[2]),
        .o_ready(rdy_o[2]), .o_fifo_count(cnt_o[2]), .o_dataline(line_o[2]),
        .o_busy(busy_o[2]), .o_send_complete(done_o[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int db(input int d);
        return (d == 0) ? 8 : 7;
    endfunction
    function automatic int pm(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
    endfunction
    function automatic int sb(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Reference model for u_d0: a queue of accepted words and the offset into
    // the frame currently on the line.
    logic [7:0] mq[$];
    bit         m_act  = 1'b0;
    int         m_off  = 0;
    logic [7:0] m_word = '0;
    bit         m_done = 1'b0;
    int         m_n;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_act  = 1'b0;
            m_off  = 0;
            m_done = 1'b0;
        end else begin
            m_n    = mq.size();
            m_done = 1'b0;
            if (m_act) begin
                if (m_off == FLEN0 - 1) begin
                    m_done = 1'b1;
                    m_act  = 1'b0;
                end else begin
                    m_off++;
                end
            end
            if (!m_act && m_n > 0) begin
                m_word = mq.pop_front();
                m_act  = 1'b1;
                m_off  = 0;
            end
            if (vld[0] && m_n < 4) mq.push_back(dat);
        end
    end

    function automatic logic model_line();
        int b;
        if (!m_act) return 1'b1;
        b = m_off / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_word[b-1];
        return 1'b1;
    endfunction

    initial forever begin
        @(negedge clk);
        chk("m_line",  line_o[0], model_line());
        chk("m_busy",  busy_o[0], m_act);
        chk("m_done",  done_o[0], m_done);
        chk("m_count", cnt_o[0],  mq.size());
        chk("m_ready", rdy_o[0],  (mq.size() < 4));
    end

    typedef struct {
        int         d;
        logic [7:0] data;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    task automatic run_vec(input int d, input logic [7:0] data, input logic exp_par, input int exp_len);
        logic       bits [16];
        logic [7:0] rx, mask;
        int         np, first, nd, np_, ns;
        nd = db(d); np_ = (pm(d) != 0) ? 1 : 0; ns = sb(d);
        mask = (nd == 8) ? 8'hFF : 8'h7F;
        for (int i = 0; i < 16; i++) bits[i] = 1'bx;
        @(negedge clk);
        dat = data; vld[d] = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        chk("line_before_start", line_o[d], 1'b1);
        @(negedge clk);
        chk("start_latency", line_o[d], 1'b0);
        chk("busy_rise", busy_o[d], 1'b1);
        np = 0; first = -1;
        for (int off = 0; off <= exp_len + 1; off++) begin
            if (off % C == C / 2 && off / C < 16) bits[off / C] = line_o[d];
            if (done_o[d]) begin
                np++;
                if (first < 0) first = off;
            end
            if (off == exp_len) chk("busy_after_frame", busy_o[d], 1'b0);
            @(negedge clk);
        end
        rx = '0;
        for (int i = 0; i < nd; i++) rx[i] = bits[1 + i];
        chk("start_bit", bits[0], 1'b0);
        chk("rx_data", rx, data & mask);
        if (np_ != 0) chk("parity_bit", bits[1 + nd], exp_par);
        for (int s = 0; s < ns; s++) chk("stop_bit", bits[1 + nd + np_ + s], 1'b1);
        chk("frame_len", first, exp_len);
        chk("pulse_once", np, 1);
    endtask

    task automatic drain(input int t0, input int np0, input int exp_n);
        int np, k;
        np = np0; k = 0;
        while ((busy_o[0] || done_o[0]) && k < 1500) begin
            @(negedge clk);
            k++;
            if (done_o[0]) begin
                np++;
                chk("pulse_time", cyc, t0 + FLEN0 * np);
            end
        end
        chk("drain_bound", (k < 1500), 1'b1);
        chk("pulse_count", np, exp_n);
    endtask

    task automatic push_burst(input int n, output int t0);
        t0 = 0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            vld[0] = 1'b1;
            dat = 8'($urandom);
            @(negedge clk);
            if (i == 1) t0 = cyc;
        end
        vld[0] = 1'b0;
    endtask

    vec_t tbl [8];

    initial begin
        int t0, np, k;
        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b0;
        tbl[0] = '{0, 8'h55, 1'b0, 100};
        tbl[1] = '{1, 8'h07, 1'b1, 110};
        tbl[2] = '{2, 8'h07, 1'b0, 110};
        tbl[3] = '{1, 8'h00, 1'b0, 110};
        tbl[4] = '{2, 8'h2A, 1'b0, 110};
        tbl[5] = '{1, 8'h7F, 1'b1, 110};
        tbl[6] = '{0, 8'hFF, 1'b0, 100};
        tbl[7] = '{2, 8'h00, 1'b1, 110};

        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_line",  line_o[d], 1'b1);
            chk("rst_busy",  busy_o[d], 1'b0);
            chk("rst_done",  done_o[d], 1'b0);
            chk("rst_ready", rdy_o[d],  1'b1);
            chk("rst_count", cnt_o[d],  3'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i].d, tbl[i].data, tbl[i].exp_par, tbl[i].exp_len);

        // Six consecutive writes into a depth-4 FIFO; the sixth is dropped.
        t0 = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            vld[0] = 1'b1;
            dat = 8'hA0 + 8'(i);
            @(negedge clk);
            if (i == 1) begin
                t0 = cyc;
                chk("fill_start", line_o[0], 1'b0);
            end
            if (i >= 4) begin
                chk("fill_ready", rdy_o[0], 1'b0);
                chk("fill_count", cnt_o[0], 3'd4);
            end
        end
        vld[0] = 1'b0;
        drain(t0, 0, 5);

        // Push lands on the same edge the first frame finishes.
        push_burst(3, t0);
        chk("pp_count_pre", cnt_o[0], 3'd2);
        while (cyc < t0 + FLEN0 - 1) @(negedge clk);
        vld[0] = 1'b1;
        dat = 8'h3C;
        @(negedge clk);
        vld[0] = 1'b0;
        chk("pp_done",  done_o[0], 1'b1);
        chk("pp_count", cnt_o[0],  3'd2);
        chk("pp_next_start", line_o[0], 1'b0);
        drain(t0, 1, 4);

        // Reset during the data bits of a frame with two words queued.
        push_burst(3, t0);
        while (cyc < t0 + 30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mr_line",  line_o[0], 1'b1);
        chk("mr_count", cnt_o[0],  3'd0);
        chk("mr_busy",  busy_o[0], 1'b0);
        chk("mr_ready", rdy_o[0],  1'b1);
        chk("mr_done",  done_o[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        np = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done_o[0]) np++;
        end
        chk("mr_no_pulse", np, 0);
        run_vec(0, 8'hC3, 1'b0, FLEN0);

        // Ten single words walk the pointers around a depth-4 FIFO.
        for (int i = 0; i < 10; i++)
            run_vec(0, 8'($urandom), 1'b0, FLEN0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            vld[0] = ($urandom_range(0, 3) == 0);
            dat = 8'($urandom);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        k = 0;
        while ((busy_o[0] || cnt_o[0] != 3'd0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("rand_drain_bound", (k < 1000), 1'b1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
